// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: request opcodes,
// FSM states and the data-memory access type.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  localparam logic [1:0] DMEM_TYPE_WORD = 2'b00;

  function automatic logic is_load(op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Purely combinational; used by both the load path and the RMW path.
module lane_align
  import mem_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_lane +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load_data = i_rdata;
    case (i_op)
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0000, w_half};
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h000000, w_byte};
      default: o_load_data = i_rdata;
    endcase
  end

  // Each byte lane takes store data only if the SB/SH targets it.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic w_sel;
    assign w_sel = ((i_op == OP_SB) && (i_lane == LANE)) ||
                   ((i_op == OP_SH) && (i_lane[1] == LANE[1]));
    assign o_merge_data[8*k +: 8] = !w_sel ? i_rdata[8*k +: 8] :
                                    (i_op == OP_SB) ? i_wdata[7:0] :
                                    i_wdata[8*(k%2) +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Sub-word stores run as a two-cycle read-modify-write with a one-cycle stall.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [4:0]  o_resp_rd,
  output logic [31:0] o_resp_data,
  output logic        o_fault,
  output logic [31:0] o_bad_addr,
  output logic        o_dmem_ena,
  output logic        o_dmem_wena,
  output logic [31:0] o_dmem_addr,
  output logic [1:0]  o_dmem_type,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata
);

  state_e      r_state, w_next;
  logic [31:0] r_merge_q, r_addr_q;
  logic        r_resp_valid, r_fault;
  logic [4:0]  r_resp_rd;
  logic [31:0] r_resp_data, r_bad_addr;

  op_e         w_op;
  logic [31:0] w_widx, w_load_data, w_merge_data;
  logic        w_misalign, w_oob, w_fault, w_accept, w_load, w_sub_store;

  assign w_op   = op_e'(i_req_op);
  assign w_widx = (i_req_addr - BASE_ADDR) >> 2;
  assign w_oob  = (i_req_addr < BASE_ADDR) || (w_widx >= 32'(DMEM_WORDS));

  always_comb begin
    w_misalign = 1'b0;
    case (w_op)
      OP_LW, OP_SW:         w_misalign = (i_req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misalign = i_req_addr[0];
      default:              w_misalign = 1'b0;
    endcase
  end

  assign w_fault     = i_req_valid && (r_state == ST_IDLE) && (w_misalign || w_oob);
  assign w_accept    = i_req_valid && (r_state == ST_IDLE) && !w_misalign && !w_oob;
  assign w_load      = w_accept && is_load(w_op);
  assign w_sub_store = w_accept && ((w_op == OP_SB) || (w_op == OP_SH));

  lane_align u_lane_align (
    .i_op         (w_op),
    .i_lane       (i_req_addr[1:0]),
    .i_rdata      (i_dmem_rdata),
    .i_wdata      (i_req_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_comb begin
    w_next       = r_state;
    o_stall      = 1'b0;
    o_dmem_ena   = 1'b0;
    o_dmem_wena  = 1'b0;
    o_dmem_addr  = w_widx;
    o_dmem_wdata = i_req_wdata;
    o_dmem_type  = DMEM_TYPE_WORD;
    // Reset gates every memory strobe so an in-flight RMW write is dropped.
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            o_dmem_ena  = 1'b1;
            o_dmem_wena = (w_op == OP_SW);
            if (w_sub_store) begin
              o_stall = 1'b1;
              w_next  = ST_RMW_WR;
            end
          end
        end
        ST_RMW_WR: begin
          o_dmem_ena   = 1'b1;
          o_dmem_wena  = 1'b1;
          o_dmem_addr  = r_addr_q;
          o_dmem_wdata = r_merge_q;
          w_next       = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_rd    <= '0;
      r_resp_data  <= '0;
      r_fault      <= 1'b0;
      r_bad_addr   <= '0;
      r_merge_q    <= '0;
      r_addr_q     <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= w_load;
      r_fault      <= w_fault;
      if (w_load) begin
        r_resp_rd   <= i_req_rd;
        r_resp_data <= w_load_data;
      end
      if (w_fault) r_bad_addr <= i_req_addr;
      if (w_sub_store) begin
        r_merge_q <= w_merge_data;
        r_addr_q  <= w_widx;
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rd    = r_resp_rd;
  assign o_resp_data  = r_resp_data;
  assign o_fault      = r_fault;
  assign o_bad_addr   = r_bad_addr;

endmodule
